// File: rtl/axis_gate_ctrl.sv
// Capture-window gate for an AXI4-Stream path: drains input and blocks output until armed and triggered, then forwards cfg_length beats.
// Zero-latency combinational datapath; backpressure from m_axis passes through only in RUN, otherwise the input is always ready.
module axis_gate_ctrl #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_arm,
  input  logic [CNTR_WIDTH-1:0]       cfg_length,
  input  logic                        trigger,
  output logic [1:0]                  sts_state,
  output logic [CNTR_WIDTH-1:0]       sts_count,
  output logic                        done,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNTR_WIDTH-1:0] count_q, count_d;
  logic [CNTR_WIDTH-1:0] len_q, len_d;
  logic                  trig_q, trig_d;
  logic                  done_q, done_d;

  logic                  run;
  logic                  trig_edge;
  logic                  hs;
  logic [CNTR_WIDTH-1:0] count_inc;

  // Gating depends only on registered state, so reset forces drain/block immediately.
  assign run           = (state_q == S_RUN);
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = run & s_axis_tvalid;
  assign s_axis_tready = run ? m_axis_tready : 1'b1;

  assign trig_edge = trigger & ~trig_q;
  assign hs        = s_axis_tvalid & m_axis_tready & run;
  assign count_inc = count_q + CNTR_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    trig_d  = trigger;
    case (state_q)
      S_IDLE: begin
        if (cfg_arm) begin
          state_d = S_ARMED;
          count_d = '0;
        end
      end
      S_ARMED: begin
        if (!cfg_arm) begin
          state_d = S_IDLE;
        end else if (trig_edge) begin
          len_d   = cfg_length;
          state_d = (cfg_length != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // A beat accepted in the abort cycle already left on m_axis, so it is counted.
        if (hs) count_d = count_inc;
        if (!cfg_arm) begin
          state_d = S_IDLE;
        end else if (hs && (count_inc == len_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!cfg_arm) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      count_q <= '0;
      len_q   <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
    end
  end

  assign sts_state = state_q;
  assign sts_count = count_q;
  assign done      = done_q;

endmodule

// File: doc/axis_gate_ctrl.md
Name: axis_gate_ctrl

Overview:
- Capture-window controller for an AXI4-Stream sample path.
- Outside a window, input is drained (s_axis_tready high) and output is blocked (m_axis_tvalid low).
- After software arms it and a trigger rising edge arrives, it forwards exactly cfg_length transfers with full backpressure, then reverts to drain/block.
- Sits between the ADC stream and DMA/FIFO writers so that upstream never stalls when no consumer is active.

Parameters:
- AXIS_TDATA_WIDTH, 16, stream data width in bits.
- CNTR_WIDTH, 32, width of the length and count registers.

Ports:
- aclk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- cfg_arm  in  1  level: 1 = arm / keep armed, 0 = abort/idle.
- cfg_length  in  CNTR_WIDTH  number of transfers per window; sampled on trigger.
- trigger  in  1  external trigger, synchronous to aclk; rising edge is used.
- sts_state  out  2  current state: 0 IDLE, 1 ARMED, 2 RUN, 3 DONE.
- sts_count  out  CNTR_WIDTH  transfers forwarded in the current or last window.
- done  out  1  high while in DONE.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  slave data.
- s_axis_tvalid  in  1  slave valid.
- s_axis_tready  out  1  slave ready.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  master data.
- m_axis_tvalid  out  1  master valid.
- m_axis_tready  in  1  master ready.

Behaviour:
- Reset (aresetn low, asynchronous):
  - state = IDLE, sts_count = 0, length register = 0, trigger-edge register = 0, done = 0.
  - s_axis_tready = 1 and m_axis_tvalid = 0, combinationally, even during reset.
- Datapath:
  - m_axis_tdata = s_axis_tdata always; no data registers; zero latency.
  - In RUN: m_axis_tvalid = s_axis_tvalid and s_axis_tready = m_axis_tready.
  - In IDLE, ARMED and DONE: s_axis_tready = 1 and m_axis_tvalid = 0.
  - Gating is decoded from registered state only, never from cfg_arm or trigger directly.
- Trigger edge: trig_q registers trigger every cycle. An edge is trigger & ~trig_q. trig_q resets to 0, so a trigger held high through reset release counts as an edge.
- Handshake: hs = s_axis_tvalid & m_axis_tready & (state == RUN).
- FSM transitions (evaluated each clock):
  - IDLE: if cfg_arm = 1, go to ARMED and clear sts_count to 0.
  - ARMED:
    - If cfg_arm = 0, go to IDLE.
    - Else, on an edge, latch cfg_length. Go to RUN if cfg_length != 0; go to DONE if cfg_length = 0.
  - RUN:
    - If cfg_arm = 0, go to IDLE (abort); sts_count holds its partial value.
    - Else, on hs, sts_count += 1. If sts_count + 1 == latched length, go to DONE.
  - DONE: hold. If cfg_arm = 0, go to IDLE. Re-arming requires cfg_arm low for at least one cycle.
- Boundary cases:
  - Edge and input valid in the same ARMED cycle: that sample is drained, not forwarded. Forwarding starts the next cycle.
  - Abort in RUN: a transfer that completes in the same cycle that cfg_arm falls is still forwarded and counted. The state is IDLE on the next cycle.
  - Triggers in RUN or DONE are ignored. A cfg_length change after the trigger has no effect on the current window.
  - Back-to-back handshakes: one count per cycle.
  - Length = 1: exactly one transfer, then DONE.
  - Length = 2^CNTR_WIDTH-1: the count cannot wrap because exit happens at equality.
  - No handshake occurs on the cycle DONE is entered.
- Status:
  - done = (state == DONE), registered.
  - sts_count is valid every cycle and holds after DONE or abort until the next IDLE→ARMED transition.

Test Plan:
- Reset with s_axis_tvalid = 1 and m_axis_tready = 0 → s_axis_tready = 1, m_axis_tvalid = 0, sts_state = 0, sts_count = 0; stays so after release with cfg_arm = 0.
- Arm, cfg_length = 5, trigger pulse, continuous valid with ready = 1 → exactly 5 m_axis handshakes with data equal to the input sequence, no gaps. Then done = 1, sts_count = 5, s_axis_tready = 1, m_axis_tvalid = 0.
- Same setup with m_axis_tready toggling 1010… → s_axis_tready mirrors m_axis_tready in RUN; 5 transfers in 9 cycles; DONE entered after the 5th handshake.
- cfg_arm dropped after 3 of 10 transfers → state IDLE next cycle, sts_count = 3, drain resumes. Re-arm clears sts_count to 0 on entering ARMED.
- cfg_length = 0 with trigger → ARMED to DONE directly, zero m_axis handshakes, sts_count = 0. Trigger held high while armed → only one window. Second trigger edge in DONE → ignored.
- Trigger edge coinciding with s_axis_tvalid = 1 in ARMED → that beat is not forwarded; the first forwarded beat is from the next cycle. aresetn asserted mid-RUN → immediate drain/block, state 0.
